// File: rtl/frame_serializer_pkg.sv
// Shared types and sizing helpers for the frame serializer.
// Optional parity beat is controlled by FRAME_SERIALIZER_PARITY_EN.
package frame_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } state_e;

  function automatic int unsigned beats_of(input int unsigned width, input int unsigned lanes);
    return width / lanes;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned beats);
    return $clog2(beats + 1);
  endfunction

endpackage

// File: rtl/frame_serializer_lane.sv
// One serial lane: shift register with registered output and, when
// FRAME_SERIALIZER_PARITY_EN is defined, an even-parity accumulator.
module frame_serializer_lane
  import frame_serializer_pkg::*;
#(
  parameter int unsigned BEATS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
`ifdef FRAME_SERIALIZER_PARITY_EN
  input  logic             par_beat,
`endif
  input  logic [BEATS-1:0] load_bits,
  output logic             serial_out
);

  logic [BEATS-1:0] shreg;

`ifdef FRAME_SERIALIZER_PARITY_EN
  logic parity;

  // Parity tracks exactly the bits already driven, so it is ready at the parity beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity <= 1'b0;
    end else if (load) begin
      parity <= load_bits[0];
    end else if (advance) begin
      parity <= parity ^ shreg[0];
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg      <= '0;
      serial_out <= 1'b0;
    end else if (load) begin
      serial_out <= load_bits[0];
      shreg      <= load_bits >> 1;
    end else if (advance) begin
      serial_out <= shreg[0];
      shreg      <= shreg >> 1;
`ifdef FRAME_SERIALIZER_PARITY_EN
    end else if (par_beat) begin
      serial_out <= parity;
`endif
    end else begin
      serial_out <= 1'b0;
    end
  end

endmodule

// File: rtl/frame_serializer.sv
// Parallel-to-serial converter: valid/ready input, one-deep hold, LANES serial lanes.
// Define FRAME_SERIALIZER_PARITY_EN to append one even-parity beat per word.
module frame_serializer
  import frame_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_msb_first,
  output logic             in_ready,
  output logic [LANES-1:0] serial_out,
  output logic             frame_out,
  output logic             busy
);

  localparam int unsigned BEATS = beats_of(WIDTH, LANES);
  localparam int unsigned CNT_W = cnt_width(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  if ((WIDTH % LANES) != 0 || BEATS < 2) begin : g_bad_cfg
    $error("frame_serializer: WIDTH must be a multiple of LANES with at least 2 beats");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hold_full_q;
  logic [WIDTH-1:0] hold_data_q;
  logic             hold_msb_q;
  logic             accept, load, advance, word_done;
`ifdef FRAME_SERIALIZER_PARITY_EN
  logic             par_beat;
`endif

  assign in_ready = ~hold_full_q;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    advance   = 1'b0;
    word_done = 1'b0;
`ifdef FRAME_SERIALIZER_PARITY_EN
    par_beat  = 1'b0;
`endif
    unique case (state_q)
      IDLE: word_done = 1'b1;
      SHIFT: begin
        if (cnt_q != LAST_BEAT) begin
          advance = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end else begin
`ifdef FRAME_SERIALIZER_PARITY_EN
          par_beat = 1'b1;
          state_d  = PARITY;
`else
          word_done = 1'b1;
`endif
        end
      end
      PARITY:  word_done = 1'b1;
      default: state_d = IDLE;
    endcase
    // End of a word (or idling): reload straight from hold to keep beats contiguous.
    if (word_done) begin
      cnt_d = '0;
      if (hold_full_q) begin
        load    = 1'b1;
        state_d = SHIFT;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      frame_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      frame_out <= (state_d == SHIFT) && (cnt_d == '0);
      busy      <= (state_d != IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      hold_msb_q  <= 1'b0;
    end else if (accept) begin
      hold_full_q <= 1'b1;
      hold_data_q <= in_data;
      hold_msb_q  <= in_msb_first;
    end else if (load) begin
      hold_full_q <= 1'b0;
    end
  end

  // MSB-first words reuse the LSB-first lane map on the bit-reversed word.
  logic [WIDTH-1:0] word;
  always_comb begin
    word = hold_data_q;
    if (hold_msb_q) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        word[i] = hold_data_q[WIDTH-1-i];
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [BEATS-1:0] lane_bits;
    for (genvar k = 0; k < BEATS; k++) begin : g_beat
      assign lane_bits[k] = word[k*LANES+l];
    end

    frame_serializer_lane #(
      .BEATS(BEATS)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .advance   (advance),
`ifdef FRAME_SERIALIZER_PARITY_EN
      .par_beat  (par_beat),
`endif
      .load_bits (lane_bits),
      .serial_out(serial_out[l])
    );
  end

endmodule
